// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a three-state IDLE/FETCH/EXEC controller.
// Holds the PC and the instruction register, issues one memory read per
// instruction and computes the next PC from the Pcsrc selection.
// Optional feature: define IF_STAGE_FETCH_CNT_EN to add the Fetch_cnt port,
// which counts accepted instruction words.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Ext_imm,
  input  logic        Stall,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic [31:0] Imem_rdata,
  input  logic        Imem_ack,
  output logic [31:0] Inst,
  output logic [5:0]  Op,
  output logic [5:0]  Func,
  output logic [31:0] Pc,
  output logic [31:0] Pc4,
  output logic        Inst_valid
`ifdef IF_STAGE_FETCH_CNT_EN
  ,
  output logic [31:0] Fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] npc_raw;
  logic        ack_take;
  logic        advance;

  assign ack_take = (state_q == FETCH) && Imem_ack;
  assign advance  = (state_q == EXEC) && !Stall;
  assign pc4      = pc_q + 32'd4;

  // State register; reset parks the controller in IDLE so any ack is ignored
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: wait for ack in FETCH, hold in EXEC while stalled
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (Imem_ack) state_d = EXEC;
      EXEC:    if (!Stall) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: a read is requested only while fetching
  always_comb begin
    Imem_req = 1'b0;
    if (state_q == FETCH) Imem_req = 1'b1;
  end

  // Next-PC selection and datapath register next values
  always_comb begin
    branch_off = Ext_imm << 2;
    case (Pcsrc)
      2'b01:   npc_raw = pc4 + branch_off;
      2'b10:   npc_raw = {pc4[31:28], inst_q[25:0], 2'b00};
      default: npc_raw = pc4;
    endcase
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (ack_take) begin
      inst_d  = Imem_rdata;
      valid_d = 1'b1;
    end
    if (advance) begin
      pc_d    = npc_raw & 32'hFFFF_FFFC;
      valid_d = 1'b0;
    end
  end

  // PC, instruction register and valid flag
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_STAGE_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Count of accepted instruction words, wraps naturally
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)         fetch_cnt_q <= '0;
    else if (ack_take) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign Fetch_cnt = fetch_cnt_q;
`endif

  assign Imem_addr  = pc_q;
  assign Pc         = pc_q;
  assign Pc4        = pc4;
  assign Inst       = inst_q;
  assign Op         = inst_q[31:26];
  assign Func       = inst_q[5:0];
  assign Inst_valid = valid_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be 00).
REQ-002 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port Clrn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port Pcsrc  in  2  next-PC select from control unit: 00 PC+4, 01 branch, 10 jump, 11 PC+4.
REQ-005 SHALL have port Ext_imm  in  32  sign-extended branch offset, in words.
REQ-006 SHALL have port Stall  in  1  hold current instruction, no PC update.
REQ-007 SHALL have port Imem_req  out  1  instruction memory read request.
REQ-008 SHALL have port Imem_addr  out  32  word-aligned fetch address.
REQ-009 SHALL have port Imem_rdata  in  32  fetched instruction word.
REQ-010 SHALL have port Imem_ack  in  1  Imem_rdata valid this cycle.
REQ-011 SHALL have port Inst  out  32  instruction register.
REQ-012 SHALL have ports Op  out  6  Inst[31:26], and Func  out  6  Inst[5:0].
REQ-013 SHALL have ports Pc  out  32  address of Inst, and Pc4  out  32  Pc+4.
REQ-014 SHALL have port Inst_valid  out  1  Inst/Op/Func valid for decode.

Function
REQ-015 SHALL implement FSM IDLE, FETCH, EXEC; IDLE->FETCH unconditionally on first clock after reset release.
REQ-016 In FETCH, Imem_req SHALL be 1 and Imem_addr SHALL equal Pc, both stable until ack.
REQ-017 FETCH with Imem_ack=1 SHALL load Inst<=Imem_rdata, set Inst_valid=1, go to EXEC on the same edge.
REQ-018 Imem_ack SHALL be ignored in IDLE and EXEC; Imem_req SHALL be 0 outside FETCH.
REQ-019 In EXEC with Stall=1, Pc, Inst, Inst_valid and state SHALL hold.
REQ-020 In EXEC with Stall=0, Pc SHALL load next PC, Inst_valid SHALL clear, state SHALL go to FETCH.
REQ-021 Next PC: 00/11 -> Pc4; 01 -> Pc4 + (Ext_imm<<2), mod 2^32; 10 -> {Pc4[31:28], Inst[25:0], 2'b00}.
REQ-022 Pc[1:0] SHALL be forced to 00 on every load.
REQ-023 Pc4 SHALL be combinational Pc+32'd4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-024 Pcsrc and Ext_imm SHALL be sampled only in EXEC with Stall=0.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (ack in first FETCH cycle).
REQ-026 Op and Func SHALL be combinational slices of Inst, valid only while Inst_valid=1.

Reset
REQ-027 Clrn=0 SHALL immediately force state IDLE, Pc=RESET_PC, Inst=0, Inst_valid=0, Imem_req=0, independent of Clk.
REQ-028 Reset asserted mid-FETCH SHALL abandon the request; any Imem_ack in or after the reset cycle before new FETCH SHALL be ignored.

Configuration
REQ-029 With macro IF_STAGE_FETCH_CNT_EN defined, SHALL add port Fetch_cnt  out  32, reset 0, incremented on each accepted ack (REQ-017), wrapping 32'hFFFF_FFFF -> 0.
REQ-030 Without IF_STAGE_FETCH_CNT_EN, Fetch_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset release, ack held 1, Pcsrc=00, Stall=0 -> Imem_addr sequence 0,4,8,...; Inst_valid high every second cycle.
REQ-032 Inst at Pc=0x10, Pcsrc=01, Ext_imm=32'hFFFF_FFFE -> next Imem_addr 0x0C.
REQ-033 Inst=32'h0800_0040 at Pc=0x3000_0000, Pcsrc=10 -> next Imem_addr 0x3000_0100.
REQ-034 Ack delayed 3 cycles -> Imem_req and Imem_addr stable 4 cycles; Stall=1 for 5 cycles in EXEC -> Inst and Pc unchanged, Imem_req=0.
REQ-035 Clrn pulsed low mid-FETCH at Pc=0x40, ack arriving during reset -> Pc=RESET_PC, Inst_valid=0, next fetch from RESET_PC.
REQ-036 With IF_STAGE_FETCH_CNT_EN, 10 fetches after reset -> Fetch_cnt=10; preloaded to 32'hFFFF_FFFF, one fetch -> 0.
